data_mem_responder: RTL and testbench

Memory-side responder for the core's data-memory interface. It serves single-word reads and writes with byte-size control, and 256-bit block reads and writes with a programmable fixed latency. It sits at the far end of the data address, read/write, size and block request/valid signals driven by the pipeline or a future data cache. It stands in for the simulator-provided memory in RTL-only benches and in a cache bring-up.

---
 rtl/data_mem_responder.sv | 150 +++++++++++++++
 tb/tb_data_mem_responder.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// Data-memory responder: combinational word reads, byte-lane word writes, and
// fixed-latency 256-bit block reads/writes sequenced by a small FSM.
module data_mem_responder #(
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter int unsigned BLK_LATENCY = 4
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic [31:0]  data_address_fC,
  input  logic         MemRead_fC,
  input  logic         MemWrite_fC,
  input  logic [31:0]  data_write_fC,
  input  logic [1:0]   data_write_size_fC,
  output logic [31:0]  data_read_2C,
  input  logic         dBlkRead_fC,
  input  logic         dBlkWrite_fC,
  input  logic [255:0] block_write_fC,
  output logic [255:0] block_read_2C,
  output logic         block_read_valid_2C,
  output logic         block_write_valid_2C,
  output logic         busy_2C
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam int unsigned CW = (BLK_LATENCY > 1) ? $clog2(BLK_LATENCY) : 1;

  if (DEPTH_WORDS < 8 || (DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0) begin : g_bad_depth
    $error("DEPTH_WORDS must be a power of 2 and at least 8");
  end
  if (BLK_LATENCY < 1) begin : g_bad_latency
    $error("BLK_LATENCY must be at least 1");
  end

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  logic [31:0]   mem [DEPTH_WORDS];
  logic [AW-1:0] word_idx;
  logic [3:0]    size_mask;
  logic [3:0]    lane_en;
  logic [31:0]   lane_data;
  logic          unused_addr_hi;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          kind_wr;
  logic [AW-1:0] blk_base;
  logic [255:0]  blk_data;
  logic          rd_valid_q;
  logic          wr_valid_q;
  logic          busy_q;
  logic          req_held;

  assign word_idx       = data_address_fC[AW+1:2];
  assign unused_addr_hi = ^data_address_fC[31:AW+2];

  // Shifting data and mask by the byte offset places byte i on lane offset+i;
  // anything pushed past lane 3 falls off the 4-bit mask.
  always_comb begin
    size_mask = 4'b1111;
    case (data_write_size_fC)
      2'd1:    size_mask = 4'b0001;
      2'd2:    size_mask = 4'b0011;
      2'd3:    size_mask = 4'b0111;
      default: size_mask = 4'b1111;
    endcase
  end

  assign lane_en   = size_mask << data_address_fC[1:0];
  assign lane_data = data_write_fC << {data_address_fC[1:0], 3'b000};

  assign data_read_2C = (MemRead_fC && RESET) ? mem[word_idx] : '0;

  // Block commit is issued after the word write so it wins on a shared word.
  always_ff @(posedge CLK) begin
    if (MemWrite_fC) begin
      for (int unsigned l = 0; l < 4; l++) begin
        if (lane_en[l]) mem[word_idx][8*l +: 8] <= lane_data[8*l +: 8];
      end
    end
    if (wr_valid_q) begin
      for (int unsigned k = 0; k < 8; k++) begin
        mem[blk_base | AW'(k)] <= blk_data[32*k +: 32];
      end
    end
  end

  always_comb begin
    block_read_2C = '0;
    if (rd_valid_q) begin
      for (int unsigned k = 0; k < 8; k++) begin
        block_read_2C[32*k +: 32] = mem[blk_base | AW'(k)];
      end
    end
  end

  assign req_held = kind_wr ? dBlkWrite_fC : dBlkRead_fC;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state      <= IDLE;
      cnt        <= '0;
      kind_wr    <= 1'b0;
      blk_base   <= '0;
      blk_data   <= '0;
      rd_valid_q <= 1'b0;
      wr_valid_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      rd_valid_q <= 1'b0;
      wr_valid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (dBlkWrite_fC || dBlkRead_fC) begin
            blk_base <= word_idx & ~AW'(7);
            blk_data <= block_write_fC;
            cnt      <= CW'(BLK_LATENCY - 1);
            kind_wr  <= dBlkWrite_fC;
            busy_q   <= 1'b1;
            state    <= BUSY;
          end
        end
        BUSY: begin
          if (!req_held) begin
            busy_q <= 1'b0;
            state  <= IDLE;
          end else if (cnt == '0) begin
            rd_valid_q <= !kind_wr;
            wr_valid_q <= kind_wr;
            state      <= DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign block_read_valid_2C  = rd_valid_q;
  assign block_write_valid_2C = wr_valid_q;
  assign busy_2C              = busy_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: a word-array reference model feeds
// expected responses into queues that a negedge monitor compares against.
module tb_data_mem_responder;
  localparam int unsigned DEPTH = 256;
  localparam int unsigned LAT   = 4;

  logic         CLK = 1'b0;
  logic         RESET;
  logic [31:0]  data_address_fC, data_write_fC, data_read_2C;
  logic         MemRead_fC, MemWrite_fC, dBlkRead_fC, dBlkWrite_fC;
  logic [1:0]   data_write_size_fC;
  logic [255:0] block_write_fC, block_read_2C;
  logic         block_read_valid_2C, block_write_valid_2C, busy_2C;

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .BLK_LATENCY(LAT)) dut (
    .CLK(CLK), .RESET(RESET),
    .data_address_fC(data_address_fC), .MemRead_fC(MemRead_fC), .MemWrite_fC(MemWrite_fC),
    .data_write_fC(data_write_fC), .data_write_size_fC(data_write_size_fC),
    .data_read_2C(data_read_2C), .dBlkRead_fC(dBlkRead_fC), .dBlkWrite_fC(dBlkWrite_fC),
    .block_write_fC(block_write_fC), .block_read_2C(block_read_2C),
    .block_read_valid_2C(block_read_valid_2C), .block_write_valid_2C(block_write_valid_2C),
    .busy_2C(busy_2C)
  );

  always #5 CLK = ~CLK;

  typedef struct { int unsigned cyc; logic [255:0] data; } blk_exp_t;

  int unsigned  checks = 0, errors = 0, cyc = 0;
  logic [31:0]  model [DEPTH];
  blk_exp_t     rdq[$], wrq[$];
  logic [31:0]  wordq[$];
  bit           exp_busy = 1'b0, commit_pend = 1'b0, chk_ends = 1'b0;
  int unsigned  commit_base;
  logic [255:0] commit_data;
  logic [31:0]  collide_val;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
    end
  endtask

  function automatic int unsigned widx(input logic [31:0] a);
    return (a >> 2) % DEPTH;
  endfunction

  function automatic void model_write(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
    int unsigned n   = (s == 2'd0) ? 4 : int'(s);
    int unsigned off = a[1:0];
    for (int unsigned i = 0; i < n; i++)
      if (off + i < 4) model[widx(a)][8*(off+i) +: 8] = d[8*i +: 8];
  endfunction

  function automatic logic [255:0] model_block(input int unsigned base);
    logic [255:0] r;
    for (int unsigned k = 0; k < 8; k++) r[32*k +: 32] = model[base + k];
    return r;
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int unsigned k = 0; k < 8; k++) r[32*k +: 32] = $urandom;
    return r;
  endfunction

  // Advance one clock; the model absorbs whatever the DUT commits at that edge.
  task automatic step();
    @(posedge CLK);
    if (RESET) begin
      if (MemWrite_fC) model_write(data_address_fC, data_write_fC, data_write_size_fC);
      if (commit_pend)
        for (int unsigned k = 0; k < 8; k++) model[commit_base + k] = commit_data[32*k +: 32];
    end
    commit_pend = 1'b0;
    cyc++;
    #2;
  endtask

  task automatic idle_ops();
    MemRead_fC = 1'b0; MemWrite_fC = 1'b0;
  endtask

  task automatic word_write(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
    data_address_fC = a; data_write_fC = d; data_write_size_fC = s;
    MemWrite_fC = 1'b1; MemRead_fC = 1'b0;
  endtask

  task automatic word_read(input logic [31:0] a);
    data_address_fC = a; MemRead_fC = 1'b1; MemWrite_fC = 1'b0;
    wordq.push_back(model[widx(a)]);
  endtask

  task automatic word_read_const(input logic [31:0] a, input logic [31:0] exp);
    data_address_fC = a; MemRead_fC = 1'b1; MemWrite_fC = 1'b0;
    wordq.push_back(exp);
  endtask

  task automatic rand_ops();
    int unsigned r = $urandom_range(0, 3);
    data_address_fC = $urandom; data_write_fC = $urandom;
    data_write_size_fC = 2'($urandom_range(0, 3));
    MemWrite_fC = r[0]; MemRead_fC = r[1];
    if (MemRead_fC) wordq.push_back(model[widx(data_address_fC)]);
  endtask

  task automatic blk_txn(input bit do_wr, input bit do_rd, input logic [31:0] addr,
                         input logic [255:0] wdata, input int unsigned abort_at,
                         input bit rnd, input bit collide);
    int unsigned base = (widx(addr) / 8) * 8;
    logic [255:0] e;
    step();
    idle_ops();
    data_address_fC = addr; block_write_fC = wdata;
    dBlkWrite_fC = do_wr; dBlkRead_fC = do_rd; exp_busy = 1'b0;
    for (int unsigned i = 1; i <= LAT; i++) begin
      step();
      exp_busy = 1'b1;
      block_write_fC = rand256();
      if (abort_at == i) begin dBlkWrite_fC = 1'b0; dBlkRead_fC = 1'b0; end
      if (collide && !do_wr && i == 1) word_write(32'((base + 1) * 4), collide_val, 2'd0);
      else if (rnd) rand_ops();
      else word_read(addr);
      if (abort_at == i) begin
        step(); exp_busy = 1'b0; idle_ops();
        return;
      end
    end
    step();
    exp_busy = 1'b1; dBlkWrite_fC = 1'b0; dBlkRead_fC = 1'b0;
    if (do_wr) begin
      wrq.push_back('{cyc, '0});
      commit_pend = 1'b1; commit_base = base; commit_data = wdata;
    end else begin
      e = model_block(base);
      rdq.push_back('{cyc, e});
    end
    if (collide && do_wr) word_write(32'((base + 1) * 4), $urandom, 2'd0);
    else if (rnd) rand_ops();
    else idle_ops();
    if (!do_wr && chk_ends) begin
      #1;
      chk("blk_rd_word0", 256'(block_read_2C[31:0]), 256'd0);
      chk("blk_rd_word7", 256'(block_read_2C[255:224]), 256'd7);
    end
    if (!do_wr && collide) begin
      #1;
      chk("blk_rd_sees_busy_write", 256'(block_read_2C[63:32]), 256'(collide_val));
    end
    step();
    exp_busy = 1'b0; idle_ops();
  endtask

  // Monitor: compares every cycle against what the scoreboard expects now.
  always @(negedge CLK) begin
    bit re, we;
    re = (rdq.size() > 0) && (rdq[0].cyc == cyc);
    we = (wrq.size() > 0) && (wrq[0].cyc == cyc);
    chk("rd_valid", 256'(block_read_valid_2C), 256'(re));
    chk("wr_valid", 256'(block_write_valid_2C), 256'(we));
    if (re) begin
      chk("blk_rd_data", block_read_2C, rdq[0].data);
      void'(rdq.pop_front());
    end else begin
      chk("blk_rd_zero", block_read_2C, '0);
    end
    if (we) void'(wrq.pop_front());
    chk("busy", 256'(busy_2C), 256'(exp_busy));
    if (RESET && MemRead_fC) begin
      if (wordq.size() == 0) begin
        checks++; errors++;
        $display("FAIL word_rd cyc=%0d actual=%h required=<none queued>", cyc, data_read_2C);
      end else begin
        chk("word_rd", 256'(data_read_2C), 256'(wordq.pop_front()));
      end
    end else begin
      chk("word_rd_zero", 256'(data_read_2C), 256'd0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    RESET = 1'b0;
    data_address_fC = '0; data_write_fC = '0; data_write_size_fC = '0;
    MemRead_fC = 1'b1; MemWrite_fC = 1'b0;
    dBlkRead_fC = 1'b0; dBlkWrite_fC = 1'b0; block_write_fC = '0;
    collide_val = 32'hCAFE0001;
    repeat (3) step();
    #1;
    chk("rst_busy", 256'(busy_2C), 256'd0);
    chk("rst_rd_valid", 256'(block_read_valid_2C), 256'd0);
    chk("rst_wr_valid", 256'(block_write_valid_2C), 256'd0);
    chk("rst_blk_rd", block_read_2C, '0);
    chk("rst_word_rd", 256'(data_read_2C), 256'd0);
    MemRead_fC = 1'b0;
    RESET = 1'b1;

    for (int unsigned w = 0; w < DEPTH; w++) begin
      step(); word_write(32'(w * 4), $urandom, 2'd0);
    end

    step(); word_write(32'h40, 32'hDEADBEEF, 2'd0);
    step(); word_read_const(32'h40, 32'hDEADBEEF);
    step(); word_write(32'h41, 32'h00000012, 2'd1);
    step(); word_read_const(32'h40, 32'hDEAD12EF);
    step(); word_write(32'h43, 32'h00005566, 2'd2);
    step(); word_read_const(32'h40, 32'h66AD12EF);
    step(); word_read_const(32'(DEPTH * 4 + 32'h40), 32'h66AD12EF);
    step(); word_write(32'h40, 32'h01020304, 2'd0); MemRead_fC = 1'b1;
    wordq.push_back(32'h66AD12EF);
    step(); word_read_const(32'h40, 32'h01020304);
    step(); word_write(32'h4E, 32'hA1B2C3D4, 2'd0);
    step(); word_read_const(32'h4C, {16'hC3D4, model[widx(32'h4C)][15:0]});

    for (int unsigned k = 0; k < 8; k++) begin
      step(); word_write(32'(32'h100 + 4 * k), 32'(k), 2'd0);
    end
    chk_ends = 1'b1;
    blk_txn(1'b0, 1'b1, 32'h10C, '0, 0, 1'b0, 1'b0);
    chk_ends = 1'b0;
    blk_txn(1'b0, 1'b1, 32'h100, '0, 0, 1'b0, 1'b1);

    blk_txn(1'b1, 1'b0, 32'h200, rand256(), 0, 1'b0, 1'b0);
    for (int unsigned k = 0; k < 8; k++) begin
      step(); word_read(32'(32'h200 + 4 * k));
    end
    blk_txn(1'b1, 1'b1, 32'h240, rand256(), 0, 1'b0, 1'b0);
    blk_txn(1'b1, 1'b1, 32'h280, rand256(), 2, 1'b0, 1'b0);
    for (int unsigned k = 0; k < 8; k++) begin
      step(); word_read(32'(32'h280 + 4 * k));
    end
    blk_txn(1'b1, 1'b0, 32'h300, rand256(), 0, 1'b0, 1'b1);

    step(); idle_ops();
    data_address_fC = 32'h2C0; block_write_fC = rand256(); dBlkWrite_fC = 1'b1; exp_busy = 1'b0;
    step(); exp_busy = 1'b1;
    step(); exp_busy = 1'b1;
    #1;
    chk("busy_before_rst", 256'(busy_2C), 256'd1);
    RESET = 1'b0; exp_busy = 1'b0; dBlkWrite_fC = 1'b0;
    #1;
    chk("rst_async_busy", 256'(busy_2C), 256'd0);
    chk("rst_async_wr_valid", 256'(block_write_valid_2C), 256'd0);
    chk("rst_async_blk_rd", block_read_2C, '0);
    step(); step();
    RESET = 1'b1;
    for (int unsigned k = 0; k < 8; k++) begin
      step(); word_read(32'(32'h2C0 + 4 * k));
    end

    for (int unsigned t = 0; t < 60; t++) begin
      int unsigned kind = $urandom_range(0, 2);
      int unsigned ab   = ($urandom_range(0, 3) == 0) ? $urandom_range(1, LAT) : 0;
      blk_txn(kind != 1, kind != 0, $urandom, rand256(), ab, 1'b1, $urandom_range(0, 4) == 0);
      repeat ($urandom_range(0, 3)) begin step(); rand_ops(); end
    end

    step(); idle_ops();
    repeat (3) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
